// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a fetch (IF) port and a data (D) port onto one single-port
//   memory with a fixed read latency. One transaction is in flight at a time.
//   The data port wins ties unless the fetch port has already lost
//   STARVE_MAX consecutive arbitrations while requesting.
//
//   state | meaning
//   IDLE  | no transaction outstanding, may grant
//   WAIT  | transaction outstanding, latency counter runs down to 0
//   RESP  | response cycle (owner's rvalid high), may grant the next access
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr                   fetch request
//   if_gnt/if_rvalid/if_rdata        fetch grant and read response
//   d_req/d_we/d_addr/d_wdata        data request (read or write)
//   d_gnt/d_rvalid/d_rdata           data grant, read response / write ack
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata   shared memory port
//   if_stall/d_stall                 request pending but not granted
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        if_stall,
    output logic        d_stall
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [2:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       owner_d;
    logic       owner_we;

    logic       arb_ok;
    logic       starve_hit;

    // Arbitration is only open in IDLE/RESP and is forced shut while in reset.
    assign arb_ok     = !rst && (state == IDLE || state == RESP);
    assign starve_hit = (starve_cnt == STARVE_LIM);

    assign d_gnt  = arb_ok && d_req && !(if_req && starve_hit);
    assign if_gnt = arb_ok && if_req && !d_gnt;

    assign mem_req   = if_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr  : (if_gnt ? if_addr : 32'h0);
    assign mem_wdata = d_gnt ? d_wdata : 32'h0;

    assign if_stall = if_req && !if_gnt;
    assign d_stall  = d_req && !d_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            starve_cnt <= 4'd0;
            owner_d    <= 1'b0;
            owner_we   <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= 32'h0;
            d_rdata    <= 32'h0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;

            // Counts arbitrations the fetch port lost while it kept requesting.
            if (!if_req || if_gnt)
                starve_cnt <= 4'd0;
            else if (d_gnt && starve_cnt < STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;

            case (state)
                IDLE, RESP: begin
                    if (mem_req) begin
                        state    <= WAIT;
                        lat_cnt  <= LAT_INIT;
                        owner_d  <= d_gnt;
                        owner_we <= d_gnt && d_we;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        state <= RESP;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            // Writes only acknowledge; read data register is untouched.
                            if (!owner_we)
                                d_rdata <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Instance u_a: MEM_LAT=2, STARVE_MAX=2. Instance u_b: MEM_LAT=1 (fetch
//   only). A behavioural memory answers MEM_LAT cycles after mem_req; a
//   transaction-level model (grant spacing, starvation count, response queue)
//   predicts every output during randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, if_stall, d_stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    logic        b_if_req;
    logic [31:0] b_if_addr, b_mem_rdata;
    logic        b_zero = 1'b0;
    logic [31:0] b_zero32 = 32'h0;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_req, b_mem_we, b_if_stall, b_d_stall;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .if_stall(if_stall), .d_stall(d_stall)
    );

    mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_zero), .d_we(b_zero), .d_addr(b_zero32), .d_wdata(b_zero32),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .if_stall(b_if_stall), .d_stall(b_d_stall)
    );

    // Behavioural memory: written words are remembered, others read a hash.
    logic [31:0] wmem [256];
    bit          wval [256];
    logic [31:0] pipe [LAT];
    logic [31:0] b_pipe;

    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        if (wval[idx]) return wmem[idx];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (mem_req && mem_we) begin
            wmem[mem_addr[9:2]] <= mem_wdata;
            wval[mem_addr[9:2]] <= 1'b1;
        end
        pipe[0] <= (mem_req && !mem_we) ? rd(mem_addr) : 32'h0BAD_0BAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        b_pipe <= b_mem_req ? rd(b_mem_addr) : 32'h0BAD_0BAD;
    end
    assign mem_rdata   = pipe[LAT-1];
    assign b_mem_rdata = b_pipe;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        b_if_req = 0; b_if_addr = 0;
    endtask

    task automatic test_reset();
        rst = 1; if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h100; b_if_req = 1;
        next_cycle();
        @(negedge clk);
        total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
        total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL rst_d_gnt: got %b want 0", d_gnt); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        total++; if (b_if_gnt !== 1'b0) begin bad++; $display("FAIL rst_b_gnt: got %b want 0", b_if_gnt); end
        total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", {if_rvalid, d_rvalid}); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
        total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
        next_cycle();
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_single_fetch();
        // Load 0x10 with DEADBEEF through a data write first.
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL preload_gnt: got %b want 1", d_gnt); end
        next_cycle();
        d_req = 0; d_we = 0; d_wdata = 0;
        repeat (3) next_cycle();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL fetch_gnt: got %b want 1", if_gnt); end
        total++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h10) begin
            bad++; $display("FAIL fetch_mem: got req/we=%b addr=%h want 10 addr=10", {mem_req, mem_we}, mem_addr); end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 1) if_req = 0;
            @(negedge clk);
            total++; if (if_rvalid !== (k == 3)) begin bad++; $display("FAIL fetch_rvalid T+%0d: got %b want %b", k, if_rvalid, (k == 3)); end
            if (k >= 3) begin
                total++; if (if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_rdata T+%0d: got %h want deadbeef", k, if_rdata); end
            end
        end
    endtask

    task automatic test_simultaneous();
        next_cycle();
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
        @(negedge clk);
        total++; if ({d_gnt, if_gnt, if_stall} !== 3'b101) begin bad++; $display("FAIL sim_T: got d/if/stall=%b want 101", {d_gnt, if_gnt, if_stall}); end
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL sim_addr: got %h want 100", mem_addr); end
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 1) d_req = 0;
            if (k == 4) if_req = 0;
            @(negedge clk);
            if (k < 3) begin
                total++; if ({if_gnt, if_stall, mem_req} !== 3'b010) begin bad++; $display("FAIL sim_wait T+%0d: got gnt/stall/req=%b want 010", k, {if_gnt, if_stall, mem_req}); end
            end
            if (k == 3) begin
                total++; if ({if_gnt, if_stall, d_rvalid} !== 3'b101) begin bad++; $display("FAIL sim_resp: got gnt/stall/drv=%b want 101", {if_gnt, if_stall, d_rvalid}); end
                total++; if (d_rdata !== rd(32'h100)) begin bad++; $display("FAIL sim_d_rdata: got %h want %h", d_rdata, rd(32'h100)); end
                total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL sim_if_addr: got %h want 40", mem_addr); end
            end
            if (k == 6) begin
                total++; if (if_rvalid !== 1'b1 || if_rdata !== rd(32'h40)) begin
                    bad++; $display("FAIL sim_if_resp: got v=%b %h want 1 %h", if_rvalid, if_rdata, rd(32'h40)); end
            end
        end
    endtask

    task automatic test_data_write();
        logic [31:0] prev;
        prev = rd(32'h100);
        next_cycle();
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55;
        @(negedge clk);
        total++; if ({d_gnt, mem_req, mem_we} !== 3'b111 || mem_wdata !== 32'h55 || mem_addr !== 32'h20) begin
            bad++; $display("FAIL wr_grant: got gnt/req/we=%b addr=%h wdata=%h want 111 20 55", {d_gnt, mem_req, mem_we}, mem_addr, mem_wdata); end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 1) begin d_req = 0; d_we = 0; d_wdata = 0; end
            @(negedge clk);
            total++; if (d_rvalid !== (k == 3)) begin bad++; $display("FAIL wr_ack T+%0d: got %b want %b", k, d_rvalid, (k == 3)); end
            total++; if (d_rdata !== prev) begin bad++; $display("FAIL wr_rdata T+%0d: got %h want %h", k, d_rdata, prev); end
        end
    endtask

    task automatic test_starvation();
        next_cycle();
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h140;
        for (int k = 0; k <= 9; k++) begin
            logic ei, ed;
            if (k > 0) next_cycle();
            @(negedge clk);
            ei = (k == 6);
            ed = (k % 3 == 0) && !ei;
            total++; if ({if_gnt, d_gnt} !== {ei, ed}) begin bad++; $display("FAIL starve k=%0d: got if/d=%b want %b", k, {if_gnt, d_gnt}, {ei, ed}); end
            if (k == 6) begin
                total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL starve_dstall: got %b want 1", d_stall); end
            end
        end
        next_cycle();
        clear_inputs();
        repeat (2) next_cycle();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt: got %b want 1", if_gnt); end
        next_cycle();
        if_req = 0; rst = 1;
        @(negedge clk);
        total++; if ({if_gnt, d_gnt, mem_req} !== 3'b000) begin bad++; $display("FAIL rmid_rst: got %b want 000", {if_gnt, d_gnt, mem_req}); end
        next_cycle();
        rst = 0;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            total++; if ({if_rvalid, d_rvalid, mem_req} !== 3'b000 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
                bad++; $display("FAIL rmid_quiet T+%0d: got v/v/req=%b rd=%h/%h want 000 0/0", k, {if_rvalid, d_rvalid, mem_req}, if_rdata, d_rdata); end
            next_cycle();
        end
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rmid_regnt: got %b want 1", if_gnt); end
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 1) if_req = 0;
            @(negedge clk);
            total++; if (if_rvalid !== (k == 3)) begin bad++; $display("FAIL rmid_rvalid T+%0d: got %b want %b", k, if_rvalid, (k == 3)); end
        end
        total++; if (if_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rmid_rdata: got %h want deadbeef", if_rdata); end
    endtask

    task automatic test_lat1();
        logic [31:0] last_data;
        last_data = 32'h0;
        next_cycle();
        b_if_req = 1; b_if_addr = 32'h300;
        for (int k = 0; k <= 10; k++) begin
            logic eg, ev;
            if (k > 0) begin
                next_cycle();
                b_if_req = (k < 10);
                if (k % 2 == 0) b_if_addr = 32'h300 + 32'(4 * k);
            end
            @(negedge clk);
            eg = (k % 2 == 0) && (k < 10);
            ev = (k >= 2) && (k % 2 == 0);
            total++; if ({b_if_gnt, b_if_rvalid} !== {eg, ev}) begin bad++; $display("FAIL lat1 k=%0d: got gnt/rv=%b want %b", k, {b_if_gnt, b_if_rvalid}, {eg, ev}); end
            if (ev) begin
                total++; if (b_if_rdata !== last_data) begin bad++; $display("FAIL lat1_rdata k=%0d: got %h want %h", k, b_if_rdata, last_data); end
            end
            if (eg) last_data = rd(b_if_addr);
        end
        next_cycle();
        clear_inputs();
    endtask

    typedef struct {
        int          due;
        bit          is_d;
        bit          we;
        logic [31:0] data;
    } resp_t;

    task automatic test_random();
        resp_t       pend[$];
        resp_t       r;
        int          last = -100;
        int          starve = 0;
        bit          gi_prev = 0, gd_prev = 0;
        logic [31:0] exp_if_rd = 0, exp_d_rd = 0;
        next_cycle();
        clear_inputs(); rst = 1;
        next_cycle();
        rst = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit elig, ei, ed, eiv, edv;
            logic [31:0] ea, ewd;
            if (cyc > 0) next_cycle();
            if (!if_req || gi_prev) begin
                if_req  = ($urandom_range(0, 99) < 55);
                if_addr = 32'h200 + 32'(4 * $urandom_range(0, 15));
            end
            if (!d_req || gd_prev) begin
                d_req   = ($urandom_range(0, 99) < 50);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = 32'h200 + 32'(4 * $urandom_range(0, 15));
                d_wdata = $urandom;
            end
            @(negedge clk);
            elig = (cyc >= last + LAT + 1);
            ed   = elig && d_req && !(if_req && starve == SMAX);
            ei   = elig && if_req && !ed;
            eiv  = 0; edv = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                if (r.is_d) begin
                    edv = 1;
                    if (!r.we) exp_d_rd = r.data;
                end else begin
                    eiv = 1;
                    exp_if_rd = r.data;
                end
            end
            total++; if ({if_gnt, d_gnt, mem_req} !== {ei, ed, ei || ed}) begin
                bad++; $display("FAIL rnd_gnt c=%0d: got if/d/req=%b want %b", cyc, {if_gnt, d_gnt, mem_req}, {ei, ed, ei || ed}); end
            total++; if ({if_stall, d_stall} !== {if_req && !ei, d_req && !ed}) begin
                bad++; $display("FAIL rnd_stall c=%0d: got %b want %b", cyc, {if_stall, d_stall}, {if_req && !ei, d_req && !ed}); end
            total++; if ({if_rvalid, d_rvalid} !== {eiv, edv}) begin
                bad++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", cyc, {if_rvalid, d_rvalid}, {eiv, edv}); end
            total++; if (if_rdata !== exp_if_rd || d_rdata !== exp_d_rd) begin
                bad++; $display("FAIL rnd_rdata c=%0d: got %h/%h want %h/%h", cyc, if_rdata, d_rdata, exp_if_rd, exp_d_rd); end
            if (ei || ed) begin
                ea  = ed ? d_addr : if_addr;
                ewd = ed ? d_wdata : 32'h0;
                total++; if (mem_addr !== ea || mem_we !== (ed && d_we) || mem_wdata !== ewd) begin
                    bad++; $display("FAIL rnd_mem c=%0d: got %h/%b/%h want %h/%b/%h", cyc, mem_addr, mem_we, mem_wdata, ea, ed && d_we, ewd); end
                r.due  = cyc + LAT + 1;
                r.is_d = ed;
                r.we   = ed && d_we;
                r.data = rd(ea);
                pend.push_back(r);
                last = cyc;
            end
            if (!if_req || ei) starve = 0;
            else if (ed && starve < SMAX) starve++;
            gi_prev = ei;
            gd_prev = ed;
        end
        next_cycle();
        clear_inputs();
        repeat (4) next_cycle();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_data_write();
        test_starvation();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
